uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- UART receive front-end sitting directly upstream of the SoC top's UART RX path; the RX pin arrives from a dedicated input (ui_in) bit.
- Synchronises the asynchronous RX line, deserialises 8N1 frames at a runtime-programmable bit period, and buffers received bytes in a small show-ahead FIFO.
- Delivers bytes to the SoC's UART register logic over a valid/ready handshake and reports framing and overrun errors.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; power of two, minimum 2.
- LVL_W, $clog2(FIFO_DEPTH+1), width of the fifo_level output.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- rx  in  1  raw UART line, asynchronous, idle high.
- div  in  16  clocks per bit; values below 4 are treated as 4.
- rd_data  out  8  head-of-FIFO byte; valid only while rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer accepts the byte; pop occurs on rd_valid&&rd_ready.
- fifo_level  out  LVL_W  current number of entries, 0..FIFO_DEPTH.
- frame_err  out  1  one-cycle pulse when a stop bit samples 0.
- overrun  out  1  sticky; set when a completed byte is dropped because the FIFO is full.
- clr_err  in  1  clears overrun; set wins if both occur in the same cycle.

Behaviour:
- Reset values: rd_valid=0, fifo_level=0, frame_err=0, overrun=0, rd_data=0, FSM=IDLE.
- Synchroniser: rx passes through two flops, reset to 1, giving rx_s. All FSM decisions use rx_s.
- Reset asserted mid-frame aborts the frame, empties the FIFO and clears all state.
- FSM states are IDLE, START, DATA, STOP and BREAK.
- IDLE:
  - rx_s==0 in cycle T0 latches the bit period P = max(div,4), clears the counter, and moves to START.
  - div changes after T0 have no effect on the current frame.
- START:
  - Sample at T0+floor(P/2).
  - rx_s==1 is a false start: return to IDLE with no push and no error.
  - Otherwise move to DATA, bit index 0, counter cleared.
- DATA:
  - Bit i (LSB first) is sampled at T0+floor(P/2)+(i+1)*P for i=0..7.
  - Move to STOP after bit 7.
- STOP: sample at T0+floor(P/2)+9*P.
  - Sample 1: push the byte.
  - Sample 0: frame_err pulses high for exactly that one cycle, the byte is discarded, and the FSM moves to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line from retriggering.
- After a good stop sample the FSM returns to IDLE in the next cycle. A new start bit can then be detected immediately; the receiver does not wait for the end of the stop bit.
- FIFO:
  - Circular buffer with separate read and write pointers plus a level counter.
  - rd_data is driven combinationally from the head entry (show-ahead).
  - A push in cycle S makes rd_valid=1 and level update in cycle S+1.
  - A pop in cycle C updates rd_data and level in cycle C+1.
  - Simultaneous push and pop: level is unchanged. This applies when full as well; the push is accepted and no overrun is flagged.
  - Push while full without a pop: the byte is dropped, overrun is set in the next cycle, and FIFO contents are untouched.
  - Pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- rd_data must hold stable while rd_valid=1 and rd_ready=0.

Test Plan:
- Single byte, div=8: send 0x55 8N1 with rd_ready=0.
  - Expect rd_valid rising at T0+4+72+1=T0+77, rd_data=0x55, fifo_level=1.
  - Assert rd_ready for one cycle: rd_valid=0 and fifo_level=0 next cycle.
- Fill and overrun, div=16, rd_ready=0: send 0x01..0x05 back-to-back.
  - fifo_level=4 and overrun=1 after the 5th stop bit.
  - Drained order is 0x01,0x02,0x03,0x04; 0x05 is lost.
  - clr_err drops overrun.
- Glitch rejection, div=8: rx low for 2 cycles, then high.
  - No push, frame_err stays 0, FSM back in IDLE.
  - A following valid 0xA3 frame is received correctly.
- Framing error, div=8: send 0x3C with stop bit 0, rx held low for 20 further bit periods, then high.
  - frame_err is one cycle wide with no push and no retrigger while low.
  - The next 0x7E frame is received.
- Full with simultaneous push/pop, FIFO holding 4 bytes: rd_ready=1 exactly on the stop-sample cycle of byte 0x99.
  - Level stays 4, overrun=0, and 0x99 is the last entry drained.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 with 2 bytes buffered.
  - All outputs return to reset values immediately.
  - After release a fresh 0xC5 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with programmable bit period and show-ahead byte FIFO
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic [15:0]      div,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t      state, state_n;
    logic        rx_meta, rx_s;
    logic [15:0] cnt, cnt_n;
    logic [15:0] period, period_n;
    logic [15:0] half;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        push;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             full, pop, wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= 16'd4;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            period  <= period_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    assign half = {1'b0, period[15:1]};

    // cnt counts cycles since the last sample point; a sample fires when it reaches the interval minus one
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        period_n  = period;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        push      = 1'b0;
        frame_err = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    period_n = (div < 16'd4) ? 16'd4 : div;
                    state_n  = START;
                end
            end
            START: begin
                if (cnt == half - 16'd1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == period - 16'd1) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == period - 16'd1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_n   = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign pop   = rd_valid && rd_ready;
    // when full, a same-cycle pop frees the head slot so the push still lands
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !pop)      level <= level + LVL_W'(1);
            else if (!wr_en && pop) level <= level - LVL_W'(1);
            if (push && full && !pop) overrun <= 1'b1;
            else if (clr_err)         overrun <= 1'b0;
        end
    end

    assign rd_data    = mem[rd_ptr];
    assign rd_valid   = (level != '0);
    assign fifo_level = level;

endmodule
